fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Sequences one shared 32-bit Q16.16 multiplier to compute a direct-form FIR output per input sample: y[n] = sum over k of coef[k]*x[n-k].
- Holds the sample delay line and the coefficient bank, issues one multiply per tap over a start/done handshake, and accumulates the products.
- Sits between the ADC sample stream and the multiplier datapath in the digital filter; output goes to the DAC/oscilloscope path.

Parameters:
- TAPS, 8, number of filter taps; power of two, 2..64.
- AW, $clog2(TAPS), width of tap and coefficient indices.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- sample_valid  in  1  input sample offered.
- sample_in  in  32  Q16.16 input sample.
- sample_ready  out  1  sequencer accepts a sample this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index.
- coef_wdata  in  32  Q16.16 coefficient.
- mul_start  out  1  one-cycle pulse: operands valid, begin multiply.
- mul_a  out  32  multiplier operand, delay-line sample.
- mul_b  out  32  multiplier operand, coefficient.
- mul_done  in  1  multiplier result valid on mul_p.
- mul_p  in  32  Q16.16 product.
- out_valid  out  1  one-cycle pulse: out_data valid.
- out_data  out  32  Q16.16 filter output.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0 at posedge clk): state IDLE; delay line, coefficient bank, accumulator, wptr and k cleared to 0. Outputs: sample_ready=1, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_data=0, busy=0. Reset in any state aborts the computation and produces no out_valid.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample_ready=1. When sample_valid=1, write sample_in to dline[wptr], clear acc, set k=0, and go to ISSUE. Otherwise stay.
- ISSUE: lasts one cycle. mul_start=1, mul_a=dline[(wptr-k) mod TAPS], mul_b=coef[k]. Go to WAIT. mul_a and mul_b hold their values until the next ISSUE.
- WAIT: stay until mul_done=1 is sampled.
  - On done, acc <= sat(acc + mul_p).
  - If k==TAPS-1, go to DONE. Otherwise k <= k+1 and go to ISSUE.
- DONE: lasts one cycle. out_valid=1, out_data=acc. out_data holds until the next DONE. wptr <= wptr+1, wrapping TAPS-1 to 0. Go to IDLE.
- Saturation: the 33-bit signed sum is clamped to 0x7FFFFFFF or 0x80000000. Each partial sum saturates on its own.
- mul_done sampled outside WAIT is ignored. mul_done in the same cycle as mul_start cannot occur, because done is only checked in WAIT.
- Latency: with the multiplier asserting done L>=1 cycles after start, one sample takes 1 (IDLE accept) + TAPS*(1+L) + 1 (DONE) cycles. The next sample is accepted in the cycle after DONE.
- Coefficient writes are honoured only when busy=0: coef[coef_addr] <= coef_wdata on the next edge. Writes while busy=1 are dropped silently.
- A simultaneous sample_valid and coef_we in IDLE performs both operations. The new coefficient is visible to that sample's taps.
- Delay line is circular. After reset, pre-history samples read as 0.

Test Plan:
- Impulse response: TAPS=8, coef[k]=0x00010000>>k (1.0, 0.5, 0.25, ...), mul_done latency 2. Send 0x00010000 followed by seven 0x0 samples -> out_data = 0x00010000, 0x00008000, 0x00004000, ... 0x00000200, each out_valid a single pulse, 26 cycles per sample.
- Saturation: all coef=0x7FFF0000, all samples 0x7FFF0000, multiplier model saturating -> out_data=0x7FFFFFFF. Negate all samples -> 0x80000000.
- Wrap-around: send 10 samples of value n+1 (Q16.16) with coef[0]=1.0 and coef[1]=1.0, others 0 -> sample 10 output = 10+9 = 0x00130000, which checks wptr wrap across index 7->0.
- Busy coefficient write: drive coef_we with coef[0]=0x00020000 while busy -> write ignored; the following output uses the old coef. The same write in IDLE takes effect.
- Reset mid-operation: assert rst in WAIT at k=3 -> next cycle busy=0, sample_ready=1, no out_valid. A later impulse shows zero history (coefs also cleared, so output 0 until reloaded).
- Variable latency: mul_done latency varied randomly 1..6 per multiply -> out_data identical to the fixed-latency run. The mul_start count per sample is exactly TAPS.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Computes one direct-form FIR output per accepted input sample,
//     y[n] = sum_k coef[k] * x[n-k]
// by sequencing a single external Q16.16 multiplier. Each tap takes one
// multiply over a mul_start / mul_done handshake. Products are summed into
// a saturating 32-bit accumulator.
//
// Ports
//   clk          clock
//   rst          synchronous, active-low reset
//   sample_valid input sample offered
//   sample_in    Q16.16 input sample
//   sample_ready high while idle; a sample is accepted when both are high
//   coef_we      coefficient write strobe, honoured only while idle
//   coef_addr    coefficient index
//   coef_wdata   Q16.16 coefficient
//   mul_start    one-cycle pulse, operands valid on mul_a / mul_b
//   mul_a        delay-line sample operand (held until the next issue)
//   mul_b        coefficient operand (held until the next issue)
//   mul_done     product valid on mul_p; only looked at while waiting
//   mul_p        Q16.16 product
//   out_valid    one-cycle pulse, filter output valid on out_data
//   out_data     Q16.16 filter output (held until the next result)
//   busy         high whenever the sequencer is not idle
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [31:0]   sample_in,
    output logic          sample_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [31:0]   coef_wdata,
    output logic          mul_start,
    output logic [31:0]   mul_a,
    output logic [31:0]   mul_b,
    input  logic          mul_done,
    input  logic [31:0]   mul_p,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t        state_q, state_d;

    logic [31:0]   dline_q [TAPS];
    logic [31:0]   coef_q  [TAPS];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] k_q;
    logic [31:0]   acc_q;
    logic [31:0]   acc_d;
    logic [31:0]   mul_a_q;
    logic [31:0]   mul_b_q;
    logic [31:0]   out_data_q;

    // Tap index wraps naturally because TAPS is a power of two.
    logic [AW-1:0] tap_idx;
    logic [31:0]   dline_rd;
    logic [31:0]   coef_rd;
    logic [32:0]   acc_sum;

    assign tap_idx  = wptr_q - k_q;
    assign dline_rd = dline_q[tap_idx];
    assign coef_rd  = coef_q[k_q];

    // Saturating add: overflow shows as a disagreement between the two top
    // bits of the sign-extended 33-bit sum.
    assign acc_sum = {acc_q[31], acc_q} + {mul_p[31], mul_p};

    always_comb begin
        acc_d = acc_sum[31:0];
        if (acc_sum[32] != acc_sum[31]) begin
            acc_d = acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    state_d = (k_q == LAST_TAP) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sample_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        mul_start    = (state_q == S_ISSUE);
        out_valid    = (state_q == S_DONE);
        // Operands are presented live during ISSUE and captured there so
        // they stay stable for the whole multiply and beyond.
        mul_a        = (state_q == S_ISSUE) ? dline_rd : mul_a_q;
        mul_b        = (state_q == S_ISSUE) ? coef_rd  : mul_b_q;
        out_data     = (state_q == S_DONE)  ? acc_q    : out_data_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_q[i] <= '0;
                coef_q[i]  <= '0;
            end
            wptr_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            out_data_q <= '0;
        end else begin
            // Coefficient bank is writable only while idle. A write in the
            // same cycle as a sample accept lands before the first ISSUE
            // reads coef[0], so the new value is seen by that sample.
            if (state_q == S_IDLE && coef_we) begin
                coef_q[coef_addr] <= coef_wdata;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        dline_q[wptr_q] <= sample_in;
                        acc_q           <= '0;
                        k_q             <= '0;
                    end
                end
                S_ISSUE: begin
                    mul_a_q <= dline_rd;
                    mul_b_q <= coef_rd;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        acc_q <= acc_d;
                        if (k_q != LAST_TAP) begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    out_data_q <= acc_q;
                    wptr_q     <= wptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_ready;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [31:0] coef_wdata = '0;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_p = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // multiplier model controls
    int lat_fixed = 2;
    bit lat_rand  = 1'b0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(TAPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_done     (mul_done),
        .mul_p        (mul_p),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Saturating Q16.16 product.
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = (pa * pb) >>> 16;
        if (p > 64'sh7FFF_FFFF)        return 32'h7FFF_FFFF;
        else if (p < -64'sh8000_0000)  return 32'h8000_0000;
        else                           return p[31:0];
    endfunction

    // Multiplier model: done arrives L cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (mul_start) begin
                int lat;
                logic [31:0] prod;
                start_cnt++;
                prod = qmul(mul_a, mul_b);
                lat  = lat_rand ? int'($urandom_range(1, 6)) : lat_fixed;
                repeat (lat) @(negedge clk);
                mul_p    = prod;
                mul_done = 1'b1;
                @(negedge clk);
                mul_done = 1'b0;
                mul_p    = '0;
            end
        end
    end

    task automatic write_coef(input logic [2:0] addr, input logic [31:0] data);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    // Offers one sample (optionally with a simultaneous coef[0] write) and
    // waits for its result. cyc counts cycles with the accept cycle as 1.
    task automatic send(input logic [31:0] x, input bit we, input logic [31:0] wdata,
                        output logic [31:0] y, output int cyc);
        int guard = 0;
        while (!sample_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        sample_in    = x;
        sample_valid = 1'b1;
        if (we) begin
            coef_we    = 1'b1;
            coef_addr  = 3'd0;
            coef_wdata = wdata;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        cyc = 2;
        while (!out_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) check_eq("timeout", {31'b0, out_valid}, 32'd1);
        y = out_data;
        @(negedge clk);
        check_eq("ov_pulse", {31'b0, out_valid}, 32'd0);
        check_eq("od_hold", out_data, y);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] y;
        int cyc;
        int ov_cnt;
        int guard;

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, sample_ready}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_start", {31'b0, mul_start}, 32'd0);
        check_eq("rst_mul_a", mul_a, 32'd0);
        check_eq("rst_mul_b", mul_b, 32'd0);
        check_eq("rst_ovalid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_odata", out_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- impulse response, latency 2 ----------------
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 32'h0001_0000 >> k);
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? 32'h0001_0000 : 32'h0, 1'b0, '0, y, cyc);
            check_eq($sformatf("imp_y%0d", n), y, 32'h0001_0000 >> n);
            check_eq($sformatf("imp_cyc%0d", n), 32'(cyc), 32'd26);
        end

        // ---------------- saturation ----------------
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 32'h7FFF_0000);
        for (int n = 0; n < TAPS; n++) begin
            send(32'h7FFF_0000, 1'b0, '0, y, cyc);
            check_eq($sformatf("sat_pos%0d", n), y, 32'h7FFF_FFFF);
        end
        for (int n = 0; n < TAPS; n++) send(32'h8001_0000, 1'b0, '0, y, cyc);
        check_eq("sat_neg", y, 32'h8000_0000);

        // ---------------- wrap-around ----------------
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0001_0000);
        for (int n = 0; n < 10; n++) begin
            send(32'(n + 1) << 16, 1'b0, '0, y, cyc);
            check_eq($sformatf("wrap_y%0d", n), y, 32'(2 * n + 1) << 16);
        end

        // ---------------- coefficient write while busy ----------------
        fork
            send(32'h0001_0000, 1'b0, '0, y, cyc);
            begin
                repeat (6) @(negedge clk);
                coef_we    = 1'b1;
                coef_addr  = 3'd0;
                coef_wdata = 32'h0002_0000;
                @(negedge clk);
                coef_we    = 1'b0;
            end
        join
        check_eq("busy_we_ignored", y, 32'h000B_0000);
        write_coef(3'd0, 32'h0002_0000);
        send(32'h0001_0000, 1'b0, '0, y, cyc);
        check_eq("idle_we_applied", y, 32'h0003_0000);
        send(32'h0001_0000, 1'b1, 32'h0003_0000, y, cyc);
        check_eq("simul_we_sample", y, 32'h0004_0000);

        // ---------------- reset mid-operation ----------------
        start_cnt    = 0;
        sample_in    = 32'h0005_0000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        guard = 0;
        while (start_cnt < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("mid_reached_k3", 32'(start_cnt), 32'd4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("mid_busy", {31'b0, busy}, 32'd0);
        check_eq("mid_ready", {31'b0, sample_ready}, 32'd1);
        check_eq("mid_ovalid", {31'b0, out_valid}, 32'd0);
        ov_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check_eq("mid_no_ov", 32'(ov_cnt), 32'd0);
        send(32'h0001_0000, 1'b0, '0, y, cyc);
        check_eq("mid_coef_cleared", y, 32'h0);
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 32'h0001_0000);
        send(32'h0001_0000, 1'b0, '0, y, cyc);
        check_eq("mid_zero_hist", y, 32'h0002_0000);

        // ---------------- variable multiplier latency ----------------
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 32'h0001_0000 >> k);
        lat_rand = 1'b1;
        for (int n = 0; n < TAPS; n++) begin
            start_cnt = 0;
            send((n == 0) ? 32'h0001_0000 : 32'h0, 1'b0, '0, y, cyc);
            check_eq($sformatf("var_y%0d", n), y, 32'h0001_0000 >> n);
            check_eq($sformatf("var_starts%0d", n), 32'(start_cnt), 32'(TAPS));
        end
        lat_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
